// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side signals of the unified memory port arbiter.
// Latency: none, wiring only.
// Backpressure: req/ack handshakes; each requester holds its request until acked.
interface mem_port_arbiter_if #(
   parameter int DATAW = 32,
   parameter int ADDRW = 32
);
   logic             if_req;
   logic [ADDRW-1:0] if_addr;
   logic             if_ack;
   logic [DATAW-1:0] if_rdata;

   logic             d_req;
   logic             d_we;
   logic [1:0]       d_size;
   logic [ADDRW-1:0] d_addr;
   logic [DATAW-1:0] d_wdata;
   logic             d_ack;
   logic [DATAW-1:0] d_rdata;

   logic             m_req;
   logic             m_we;
   logic [1:0]       m_size;
   logic [ADDRW-1:0] m_addr;
   logic [DATAW-1:0] m_wdata;
   logic             m_ack;
   logic [DATAW-1:0] m_rdata;

   // Arbiter side
   modport slave (
      input  if_req, if_addr,
      output if_ack, if_rdata,
      input  d_req, d_we, d_size, d_addr, d_wdata,
      output d_ack, d_rdata,
      output m_req, m_we, m_size, m_addr, m_wdata,
      input  m_ack, m_rdata
   );

   // Requester/memory side
   modport master (
      output if_req, if_addr,
      input  if_ack, if_rdata,
      output d_req, d_we, d_size, d_addr, d_wdata,
      input  d_ack, d_rdata,
      input  m_req, m_we, m_size, m_addr, m_wdata,
      output m_ack, m_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store, data first with bounded fetch starvation.
// Latency: m_req the cycle after the IDLE grant; requester ack the cycle after m_ack.
// Backpressure: one transaction at a time; the losing requester waits with its request held.
module mem_port_arbiter #(
   parameter int DATAW        = 32,
   parameter int ADDRW        = 32,
   parameter int MAX_D_STREAK = 4
) (
   input  logic              clock,
   input  logic              reset,
   mem_port_arbiter_if.slave bus,
   output logic              busy
);
   localparam int SW = $clog2(MAX_D_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t           state,       state_n;
   logic             owner_fetch, owner_fetch_n;
   logic [SW-1:0]    d_streak,    d_streak_n;
   logic             m_req_r,     m_req_n;
   logic             m_we_r,      m_we_n;
   logic [1:0]       m_size_r,    m_size_n;
   logic [ADDRW-1:0] m_addr_r,    m_addr_n;
   logic [DATAW-1:0] m_wdata_r,   m_wdata_n;
   logic [DATAW-1:0] if_rdata_r,  if_rdata_n;
   logic [DATAW-1:0] d_rdata_r,   d_rdata_n;
   logic             if_ack_r,    if_ack_n;
   logic             d_ack_r,     d_ack_n;
   logic             busy_r,      busy_n;

   always_comb begin
      state_n       = state;
      owner_fetch_n = owner_fetch;
      d_streak_n    = d_streak;
      m_req_n       = m_req_r;
      m_we_n        = m_we_r;
      m_size_n      = m_size_r;
      m_addr_n      = m_addr_r;
      m_wdata_n     = m_wdata_r;
      if_rdata_n    = if_rdata_r;
      d_rdata_n     = d_rdata_r;
      if_ack_n      = 1'b0;
      d_ack_n       = 1'b0;

      case (state)
         IDLE: begin
            // Fetch wins outright, or on a tie once data has used up its streak.
            if (bus.if_req && (!bus.d_req || d_streak == STREAK_MAX)) begin
               owner_fetch_n = 1'b1;
               m_we_n        = 1'b0;
               m_size_n      = 2'b10;
               m_addr_n      = bus.if_addr;
               m_wdata_n     = '0;
               m_req_n       = 1'b1;
               d_streak_n    = '0;
               state_n       = ISSUE;
            end else if (bus.d_req) begin
               owner_fetch_n = 1'b0;
               m_we_n        = bus.d_we;
               m_size_n      = bus.d_size;
               m_addr_n      = bus.d_addr;
               m_wdata_n     = bus.d_wdata;
               m_req_n       = 1'b1;
               state_n       = ISSUE;
               if (!bus.if_req) begin
                  d_streak_n = '0;
               end else if (d_streak != STREAK_MAX) begin
                  d_streak_n = d_streak + 1'b1;
               end
            end
         end
         ISSUE: begin
            if (bus.m_ack) begin
               m_req_n = 1'b0;
               if (owner_fetch) begin
                  if_rdata_n = bus.m_rdata;
                  if_ack_n   = 1'b1;
               end else begin
                  if (!m_we_r) d_rdata_n = bus.m_rdata;
                  d_ack_n = 1'b1;
               end
               state_n = RESP;
            end
         end
         RESP: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         owner_fetch <= 1'b0;
         d_streak    <= '0;
         m_req_r     <= 1'b0;
         m_we_r      <= 1'b0;
         m_size_r    <= 2'b00;
         m_addr_r    <= '0;
         m_wdata_r   <= '0;
         if_rdata_r  <= '0;
         d_rdata_r   <= '0;
         if_ack_r    <= 1'b0;
         d_ack_r     <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state       <= state_n;
         owner_fetch <= owner_fetch_n;
         d_streak    <= d_streak_n;
         m_req_r     <= m_req_n;
         m_we_r      <= m_we_n;
         m_size_r    <= m_size_n;
         m_addr_r    <= m_addr_n;
         m_wdata_r   <= m_wdata_n;
         if_rdata_r  <= if_rdata_n;
         d_rdata_r   <= d_rdata_n;
         if_ack_r    <= if_ack_n;
         d_ack_r     <= d_ack_n;
         busy_r      <= busy_n;
      end
   end

   assign bus.m_req    = m_req_r;
   assign bus.m_we     = m_we_r;
   assign bus.m_size   = m_size_r;
   assign bus.m_addr   = m_addr_r;
   assign bus.m_wdata  = m_wdata_r;
   assign bus.if_rdata = if_rdata_r;
   assign bus.d_rdata  = d_rdata_r;
   assign bus.if_ack   = if_ack_r;
   assign bus.d_ack    = d_ack_r;
   assign busy         = busy_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Latency: n/a. Backpressure: bench acts as both requesters and the memory.
// The model tracks grant/ack cycle numbers per transaction rather than FSM states.
module tb_mem_port_arbiter;
   localparam int DATAW = 32;
   localparam int ADDRW = 32;
   localparam int MAXS  = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic busy;

   mem_port_arbiter_if #(.DATAW(DATAW), .ADDRW(ADDRW)) bus ();

   mem_port_arbiter #(.DATAW(DATAW), .ADDRW(ADDRW), .MAX_D_STREAK(MAXS)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Transaction-level reference
   bit          md_inflight = 1'b0;
   int          md_tgrant   = 0;
   int          md_tmack    = -1;
   bit          md_fetch    = 1'b0;
   logic        md_we       = 1'b0;
   logic [1:0]  md_size     = 2'b00;
   logic [31:0] md_addr     = '0;
   logic [31:0] md_wdata    = '0;
   logic [31:0] md_if_rd    = '0;
   logic [31:0] md_d_rd     = '0;
   int          md_streak   = 0;

   int mreq_age   = 0;
   int f_wait     = 0;
   int f_wait_max = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Predicts what the arbiter has committed to by the end of the current cycle.
   task automatic model_update();
      if (reset) begin
         md_inflight = 1'b0;
         md_tmack    = -1;
         md_streak   = 0;
         md_we       = 1'b0;
         md_size     = 2'b00;
         md_addr     = '0;
         md_wdata    = '0;
         md_if_rd    = '0;
         md_d_rd     = '0;
      end else begin
         if (md_inflight && md_tmack >= 0 && cyc >= md_tmack + 2) md_inflight = 1'b0;
         if (md_inflight) begin
            if (md_tmack < 0 && cyc > md_tgrant && bus.m_ack) begin
               md_tmack = cyc;
               if (md_fetch) md_if_rd = bus.m_rdata;
               else if (!md_we) md_d_rd = bus.m_rdata;
            end
         end else if (bus.if_req && (!bus.d_req || md_streak == MAXS)) begin
            md_inflight = 1'b1; md_tgrant = cyc; md_tmack = -1; md_fetch = 1'b1;
            md_we = 1'b0; md_size = 2'b10; md_addr = bus.if_addr; md_wdata = '0;
            md_streak = 0;
         end else if (bus.d_req) begin
            md_inflight = 1'b1; md_tgrant = cyc; md_tmack = -1; md_fetch = 1'b0;
            md_we = bus.d_we; md_size = bus.d_size; md_addr = bus.d_addr; md_wdata = bus.d_wdata;
            md_streak = bus.if_req ? ((md_streak < MAXS) ? md_streak + 1 : MAXS) : 0;
         end
      end
   endtask

   task automatic compare_outputs();
      bit ex_mreq = md_inflight && (md_tmack < 0);
      bit ack_now = md_inflight && (md_tmack == cyc - 1);
      bit ex_busy = md_inflight && (md_tmack < 0 || cyc <= md_tmack + 1);
      check("m_req",    bus.m_req,    ex_mreq);
      check("if_ack",   bus.if_ack,   ack_now && md_fetch);
      check("d_ack",    bus.d_ack,    ack_now && !md_fetch);
      check("busy",     busy,         ex_busy);
      check("m_we",     bus.m_we,     md_we);
      check("m_size",   bus.m_size,   md_size);
      check("m_addr",   bus.m_addr,   md_addr);
      check("m_wdata",  bus.m_wdata,  md_wdata);
      check("if_rdata", bus.if_rdata, md_if_rd);
      check("d_rdata",  bus.d_rdata,  md_d_rd);
   endtask

   task automatic tick();
      model_update();
      @(posedge clock);
      #1;
      cyc++;
      compare_outputs();
   endtask

   task automatic env_random();
      if (bus.if_req && !bus.if_ack) f_wait++;
      else f_wait = 0;
      if (f_wait > f_wait_max) f_wait_max = f_wait;

      if (bus.if_ack || !bus.if_req) begin
         bus.if_req  = ($urandom_range(0, 2) != 0);
         bus.if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (bus.d_ack || !bus.d_req) begin
         bus.d_req   = ($urandom_range(0, 1) != 0);
         bus.d_we    = 1'($urandom_range(0, 1));
         bus.d_size  = 2'($urandom_range(0, 2));
         bus.d_addr  = $urandom;
         bus.d_wdata = $urandom;
      end
      if (bus.m_req) mreq_age++;
      else mreq_age = 0;
      bus.m_ack   = bus.m_req ? (mreq_age >= 6 || $urandom_range(0, 1) == 1)
                              : ($urandom_range(0, 9) == 0);
      bus.m_rdata = $urandom;
      reset = ($urandom_range(0, 599) == 0);
      if (reset) begin
         bus.if_req = 1'b0;
         bus.d_req  = 1'b0;
      end
   endtask

   initial begin
      string order;
      int    nreq;
      int    nack;
      bit    done;

      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 2'b00; bus.d_addr = '0; bus.d_wdata = '0;
      bus.m_ack = 1'b0; bus.m_rdata = '0;

      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_m_req", bus.m_req, 0);
      check("rst_m_addr", bus.m_addr, 0);
      reset = 1'b0;
      tick();

      // Single fetch, memory acks in the first ISSUE cycle
      bus.if_req = 1'b1; bus.if_addr = 32'h0100_0000;
      tick();
      check("t1_m_req", bus.m_req, 1);
      check("t1_m_size", bus.m_size, 2'b10);
      check("t1_m_addr", bus.m_addr, 32'h0100_0000);
      bus.m_ack = 1'b1; bus.m_rdata = 32'h0000_0013;
      tick();
      bus.m_ack = 1'b0;
      check("t1_if_ack", bus.if_ack, 1);
      check("t1_m_req_drop", bus.m_req, 0);
      check("t1_if_rdata", bus.if_rdata, 32'h0000_0013);
      bus.if_req = 1'b0;
      tick();
      check("t1_busy_low", busy, 0);

      // Load vs fetch tie: load first, fetch sampled at the next IDLE
      bus.if_req = 1'b1; bus.if_addr = 32'h0100_0004;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'b10; bus.d_addr = 32'h0100_0100;
      tick();
      check("t2_m_addr", bus.m_addr, 32'h0100_0100);
      check("t2_m_we", bus.m_we, 0);
      bus.m_ack = 1'b1; bus.m_rdata = 32'hCAFE_0001;
      tick();
      bus.m_ack = 1'b0;
      check("t2_d_ack", bus.d_ack, 1);
      check("t2_d_rdata", bus.d_rdata, 32'hCAFE_0001);
      bus.d_req = 1'b0;
      tick();
      check("t2_idle_c3", busy, 0);
      tick();
      check("t2_fetch_m_req", bus.m_req, 1);
      check("t2_fetch_addr", bus.m_addr, 32'h0100_0004);
      bus.m_ack = 1'b1; bus.m_rdata = 32'h0000_0093;
      tick();
      bus.m_ack = 1'b0;
      check("t2_if_ack", bus.if_ack, 1);
      bus.if_req = 1'b0;
      tick();

      // Byte store leaves d_rdata alone
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'b00;
      bus.d_addr = 32'h0100_0200; bus.d_wdata = 32'h0000_00AB;
      tick();
      check("t3_m_we", bus.m_we, 1);
      check("t3_m_size", bus.m_size, 2'b00);
      check("t3_m_wdata", bus.m_wdata, 32'h0000_00AB);
      bus.m_ack = 1'b1; bus.m_rdata = 32'h5555_5555;
      tick();
      bus.m_ack = 1'b0;
      check("t3_d_ack", bus.d_ack, 1);
      check("t3_d_rdata_kept", bus.d_rdata, 32'hCAFE_0001);
      bus.d_req = 1'b0;
      tick();

      // Both requesters held high: fetch gets every fifth slot
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_1000;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'b10; bus.d_addr = 32'h0000_2000;
      order = "";
      done = 1'b0;
      for (int i = 0; i < 80 && !done; i++) begin
         tick();
         if (bus.m_req) begin
            if (bus.m_addr == 32'h0000_1000) order = {order, "F"};
            else order = {order, "D"};
         end
         bus.m_ack = bus.m_req;
         if ((bus.if_ack || bus.d_ack) && order.len() >= 10) begin
            bus.if_req = 1'b0;
            bus.d_req  = 1'b0;
            done = 1'b1;
         end
      end
      bus.m_ack = 1'b0;
      tick();
      tick();
      n_checks++;
      if (order != "DDDDFDDDDF") begin
         n_fail++;
         $display("FAIL t4_grant_order: got %s expected DDDDFDDDDF", order);
      end

      // Reset while the memory is still working on a fetch
      bus.if_req = 1'b1; bus.if_addr = 32'h0100_0300;
      tick();
      check("t5_m_req_c1", bus.m_req, 1);
      tick();
      check("t5_m_req_c2", bus.m_req, 1);
      reset = 1'b1; bus.if_req = 1'b0;
      tick();
      reset = 1'b0;
      check("t5_m_req_rst", bus.m_req, 0);
      check("t5_busy_rst", busy, 0);
      check("t5_if_ack_rst", bus.if_ack, 0);
      check("t5_if_rdata_rst", bus.if_rdata, 0);
      tick();
      tick();
      bus.m_ack = 1'b1; bus.m_rdata = 32'hDEAD_BEEF;
      tick();
      bus.m_ack = 1'b0;
      check("t5_stray_if_ack", bus.if_ack, 0);
      check("t5_stray_busy", busy, 0);
      tick();
      check("t5_stray_if_rdata", bus.if_rdata, 0);

      // Load request held for two cycles past its ack
      nreq = 0;
      nack = 0;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'b10; bus.d_addr = 32'h0100_0400;
      tick();
      for (int i = 1; i <= 9; i++) begin
         if (bus.m_req) nreq++;
         if (bus.d_ack) nack++;
         bus.m_ack = bus.m_req;
         bus.m_rdata = 32'h1000_0000 + 32'(i);
         if (i == 5) bus.d_req = 1'b0;
         tick();
      end
      bus.m_ack = 1'b0;
      check("t6_mem_txns", 64'(nreq), 2);
      check("t6_d_acks", 64'(nack), 2);
      tick();

      // Randomized traffic with occasional resets
      for (int i = 0; i < 4000; i++) begin
         env_random();
         tick();
      end
      reset = 1'b0;
      n_checks++;
      if (f_wait_max > 60) begin
         n_fail++;
         $display("FAIL fetch_starvation: waited %0d cycles, limit 60", f_wait_max);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares one single-port unified memory between the instruction-fetch requester and the data-access (load/store) requester of the pipelined core. It runs one transaction at a time, with data-side priority and a bounded fetch-starvation guarantee. It returns registered read data and a one-cycle acknowledge to the winning requester.

## Interface
Parameters:
- DATAW, 32, data width of all read/write data buses
- ADDRW, 32, byte-address width
- MAX_D_STREAK, 4, maximum consecutive data grants while a fetch is pending (must be ≥1)

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- if_req  input  1  fetch request; held high with stable if_addr until if_ack
- if_addr  input  ADDRW  fetch address
- if_ack  output  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  output  DATAW  registered fetched instruction
- d_req  input  1  data request; held high with stable d_we/d_size/d_addr/d_wdata until d_ack
- d_we  input  1  1 = store, 0 = load
- d_size  input  2  access size (00 byte, 01 half, 10 word), passed through unchanged
- d_addr  input  ADDRW  data address
- d_wdata  input  DATAW  store data
- d_ack  output  1  one-cycle pulse: data access complete
- d_rdata  output  DATAW  registered load data
- m_req  output  1  memory request, held until m_ack
- m_we  output  1  memory write enable (0 for fetch)
- m_size  output  2  access size (10 for fetch)
- m_addr  output  ADDRW  memory address
- m_wdata  output  DATAW  memory write data (0 for fetch)
- m_ack  input  1  memory completion pulse; m_rdata valid in same cycle for reads
- m_rdata  input  DATAW  memory read data
- busy  output  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE, arbitration (sampled every IDLE cycle):
  - Only if_req → fetch wins.
  - Only d_req → data wins.
  - Both → data wins, unless d_streak == MAX_D_STREAK, in which case fetch wins.
  - Neither → stay in IDLE.
  - On a win: latch owner, m_we/m_size/m_addr/m_wdata from the winner, and go to ISSUE.
- ISSUE: m_req=1 with latched fields constant. On m_ack: latch m_rdata into if_rdata (fetch owner) or into d_rdata (data owner, only when m_we=0), then go to RESP.
- RESP: pulse if_ack or d_ack for the owner. Ignore all requests. Go to IDLE next cycle.
- d_streak, width $clog2(MAX_D_STREAK+1):
  - +1 on a data grant while if_req=1, saturating at MAX_D_STREAK.
  - Cleared on any fetch grant.
  - Cleared on a data grant with if_req=0.
- A requester must deassert req, or present a new request, by the cycle after its ack. Because RESP ignores requests, a still-high req is never double-granted.
- m_ack outside ISSUE is ignored.
- Stores do not modify d_rdata.
- Reset values, all outputs: if_ack=0, d_ack=0, m_req=0, m_we=0, m_size=0, m_addr=0, m_wdata=0, if_rdata=0, d_rdata=0, busy=0. State=IDLE, d_streak=0.

## Timing
- All outputs are registered; no combinational path from input to output.
- Request sampled in IDLE at cycle 0 → m_req high from cycle 1.
- m_ack may arrive in any ISSUE cycle, including cycle 1.
- m_ack at cycle k → ack pulse at cycle k+1 → IDLE at cycle k+2.
- Minimum turnaround is 3 cycles per transaction (req 0, m_req 1, ack 2, next sample 3).
- A data request arriving while a fetch is in flight waits. It is granted in the first IDLE cycle, subject to arbitration.
- Reset asserted mid-transaction: next cycle the FSM is in IDLE with all outputs at reset values. The in-flight transaction is abandoned and no ack is issued. The memory is reset on the same signal.
- A fetch pending continuously is granted within MAX_D_STREAK data transactions.

## Test plan
- Single fetch: if_req=1, if_addr=0x01000000; memory acks at cycle 1 with 0x00000013 → m_req high cycle 1 only, m_size=10, if_ack cycle 2, if_rdata=0x00000013, busy low cycle 3.
- Load vs fetch tie: both requests at cycle 0, d_addr=0x01000100, d_we=0 → data granted first, d_rdata=m_rdata. Fetch granted at the next IDLE (cycle 3 for a 1-cycle memory).
- Store: d_we=1, d_size=00, d_wdata=0xAB → m_we=1, m_size=00, m_wdata=0xAB; d_ack pulses; d_rdata unchanged from previous load.
- Starvation bound, MAX_D_STREAK=4: if_req and d_req held high continuously → grant order D,D,D,D,F,D,D,D,D,F.
- Reset mid-transaction: reset at cycle 2 with m_req high and m_ack delayed 5 cycles → cycle 3 m_req=0, busy=0, no if_ack/d_ack. A stray m_ack afterwards is ignored.
- Held request: requester keeps d_req=1 for 2 cycles after d_ack → exactly one memory transaction per original request. The held request is treated as a new request only once sampled in IDLE.
